// File: rtl/game_state_hist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_state_hist_pkg
// Description : Shared game constants and history command encoding.
// Revision    : 1.0
// ============================================================================
package game_state_hist_pkg;

    localparam int STATE_W = 134;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_CLR  = 2'd1,
        CMD_LOAD = 2'd2,
        CMD_UNDO = 2'd3
    } cmd_e;

    // Priority clr > load > undo; a blocked load still masks undo.
    function automatic cmd_e cmd_sel(
        input logic clr,
        input logic load,
        input logic load_blocked,
        input logic undo_ok
    );
        if (clr)
            return CMD_CLR;
        if (load)
            return load_blocked ? CMD_NONE : CMD_LOAD;
        if (undo_ok)
            return CMD_UNDO;
        return CMD_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_state_hist_ram.sv
`default_nettype none
// ============================================================================
// Module      : game_state_hist_ram
// Description : DEPTH x W history store, one write port, async read port.
// Revision    : 1.0
// ============================================================================
module game_state_hist_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i)
            mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/game_state_hist.sv
`default_nettype none
// ============================================================================
// Module      : game_state_hist
// Description : Game-state register with a circular multi-level undo history.
// Revision    : 1.0
// ============================================================================
module game_state_hist
    import game_state_hist_pkg::*;
#(
    parameter int             W     = STATE_W,
    parameter int             DEPTH = 8,
    parameter logic [W-1:0]   INIT  = {W{1'b0}},
    parameter int             DEDUP = 1
) (
    input  logic                       clk,
    input  logic                       r_n,
    input  logic                       clr,
    input  logic                       load,
    input  logic                       undo,
    input  logic [W-1:0]               d,
    output logic [W-1:0]               q,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       undo_avail,
    output logic                       full
);

    localparam int               WP_W     = $clog2(DEPTH);
    localparam int               CNT_W    = $clog2(DEPTH+1);
    localparam logic [WP_W-1:0]  WP_LAST  = WP_W'(DEPTH-1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [W-1:0]     q_q, q_d;
    logic [WP_W-1:0]  wp_q, wp_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [WP_W-1:0]  wp_inc, wp_dec;
    logic [W-1:0]     hist_rd;
    logic             hist_we;
    cmd_e             cmd;

    // Explicit compares keep wrap correct for non-power-of-two DEPTH.
    assign wp_inc = (wp_q == WP_LAST) ? '0 : wp_q + 1'b1;
    assign wp_dec = (wp_q == '0) ? WP_LAST : wp_q - 1'b1;

    assign cmd = cmd_sel(clr, load, (DEDUP != 0) && (d == q_q), count_q != '0 && undo);
    assign hist_we = (cmd == CMD_LOAD);

    game_state_hist_ram #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (WP_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (hist_we),
        .waddr_i (wp_q),
        .wdata_i (q_q),
        .raddr_i (wp_dec),
        .rdata_o (hist_rd)
    );

    always_comb begin
        q_d     = q_q;
        wp_d    = wp_q;
        count_d = count_q;
        unique case (cmd)
            CMD_CLR: begin
                q_d     = INIT;
                wp_d    = '0;
                count_d = '0;
            end
            CMD_LOAD: begin
                q_d     = d;
                wp_d    = wp_inc;
                count_d = (count_q == CNT_FULL) ? count_q : count_q + 1'b1;
            end
            CMD_UNDO: begin
                q_d     = hist_rd;
                wp_d    = wp_dec;
                count_d = count_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            q_q     <= INIT;
            wp_q    <= '0;
            count_q <= '0;
        end else begin
            q_q     <= q_d;
            wp_q    <= wp_d;
            count_q <= count_d;
        end
    end

    assign q          = q_q;
    assign count      = count_q;
    assign undo_avail = (count_q != '0);
    assign full       = (count_q == CNT_FULL);

endmodule
`default_nettype wire

// File: doc/game_state_hist.md
Name: game_state_hist

Overview:
- Parametrised successor to the plain enabled state register.
- Holds the current game-state vector and a circular history of up to DEPTH previous states, giving multi-step undo.
- Sits between the move-resolution logic (which presents the next state) and the renderer/win-check logic (which consume `q`).

Parameters:
- W, 134, width of the game-state vector in bits.
- DEPTH, 8, number of undo levels stored (>= 2; need not be a power of two).
- INIT, {W{1'b0}}, value loaded into `q` on reset and on `clr`.
- DEDUP, 1, when 1 a `load` whose `d` equals `q` is ignored (blocked move consumes no history).

Ports:
- clk  input  1  rising-edge clock.
- r_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear: `q`<=INIT, history emptied.
- load  input  1  commit `d` as new current state, pushing old `q` into history.
- undo  input  1  restore most recent history entry into `q`.
- d  input  W  next state from move logic.
- q  output  W  current state.
- count  output  $clog2(DEPTH+1)  number of valid history entries.
- undo_avail  output  1  `count` != 0.
- full  output  1  `count` == DEPTH.

Behaviour:
- Reset (`r_n`=0, asynchronous):
  - `q`=INIT, `count`=0, write pointer `wp`=0.
  - `undo_avail`=0, `full`=0.
  - History RAM contents are don't-care and need not be reset.
- Per-cycle command priority: `clr` > `load` > `undo`. At most one action per edge.
- clr:
  - `q`<=INIT, `count`<=0, `wp`<=0.
  - `load` and `undo` in the same cycle are ignored.
- load (effective when `clr`=0, and, if DEDUP=1, `d`!=`q`):
  - `hist[wp]`<=`q`; `q`<=`d`.
  - `wp`<=(`wp`==DEPTH-1) ? 0 : `wp`+1.
  - `count`<=min(`count`+1, DEPTH).
- load when full: the oldest entry is overwritten (it sits at `wp` when `count`==DEPTH). `count` stays DEPTH and `full` stays 1.
- load with DEDUP=1 and `d`==`q`: no state change at all. A simultaneous `undo` is also ignored, because `load` still holds priority.
- undo (effective when `clr`=0, `load`=0, `count`!=0):
  - `q`<=`hist[wp-1]`, with wrap: index DEPTH-1 when `wp`=0.
  - `wp`<=`wp`-1 with wrap; `count`<=`count`-1.
- undo with `count`==0: ignored; `q` holds.
- Latency: one cycle. The new `q`/`count` are visible after the edge on which the command is sampled.
- `undo_avail` and `full` are combinational decodes of `count` registers; no extra latency.
- No handshake: commands are single-cycle level-sampled. Holding `undo` high pops one entry per cycle until empty.
- Reset asserted mid-sequence: everything returns to reset values immediately, independent of `clk`.
- Arithmetic:
  - `wp` is $clog2(DEPTH) bits.
  - Wrap is by explicit compare, never by natural overflow, so non-power-of-two DEPTH is correct.

Decomposition:
- Shared game package holds:
  - `STATE_W`=134 (board-state width), used as default W by all instantiations.
  - Command-priority encoding (CMD_NONE/CLR/LOAD/UNDO) if other blocks need to decode it.
- One natural sub-module: `hist_ram` (DEPTH x W).
  - Single write port, one asynchronous read port at address `wp`-1.
  - Lets synthesis map to distributed RAM.
- Pointer/count logic stays in the top module.

Test Plan (W=8, DEPTH=4, INIT=8'h00, DEDUP=1):
- Reset then three loads `d`=8'h11, 8'h22, 8'h33 -> `q`=8'h33, `count`=3, `undo_avail`=1, `full`=0.
- From that state, three undos -> `q` steps 8'h22, 8'h11, 8'h00; `count`=0. A fourth undo leaves `q`=8'h00, `count`=0.
- Six loads 8'h01..8'h06 -> `count`=4, `full`=1. Four undos give 8'h05, 8'h04, 8'h03, 8'h02. A fifth undo is ignored (8'h01 was overwritten).
- `load` with `d`==`q`=8'h22 -> `q` and `count` unchanged. Same cycle with `load`+`undo`, `d`=8'h44 -> `q`=8'h44, `count`+1, no pop.
- `clr` asserted together with `load`(`d`=8'h55) and `count`=2 -> `q`=8'h00, `count`=0; a following undo is ignored.
- Drive `r_n` low between clock edges while `count`=3 -> `q`=8'h00, `count`=0 before the next edge; resume loads correctly after release.
